// File: rtl/shiftreg_piso_stream.sv
// Parallel-in, serial-out shift register with valid/ready on both sides and a
// one-word holding buffer so consecutive words serialise without bubbles.

(* tamara_triplicate *)
module shiftreg_piso_stream #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic [LANES-1:0] sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready,
    (* tamara_error_sink *)
    output logic             err
);

    localparam int BEATS = WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
            $error("shiftreg_piso_stream: LANES must be >= 1 and divide WIDTH");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never waits on ready, and ready never waits on valid.

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             busy_q, busy_d;
    logic             hold_valid_q, hold_valid_d;

    logic [WIDTH-1:0] sreg_shifted;
    logic             in_xfer;
    logic             beat_xfer;
    logic             at_last;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sout         = sreg_q[WIDTH-1 -: LANES];
            assign sreg_shifted = sreg_q << LANES;
        end else begin : g_lsb
            assign sout         = sreg_q[LANES-1:0];
            assign sreg_shifted = sreg_q >> LANES;
        end
    endgenerate

    assign in_ready   = !rst && !hold_valid_q;
    assign sout_valid = busy_q;
    assign at_last    = (beat_q == LAST_BEAT);
    assign sout_last  = busy_q && at_last;
    assign err        = 1'b0;

    assign in_xfer    = in_valid && in_ready;
    assign beat_xfer  = busy_q && sout_ready;

    always_comb begin
        sreg_d       = sreg_q;
        hold_d       = hold_q;
        beat_d       = beat_q;
        busy_d       = busy_q;
        hold_valid_d = hold_valid_q;

        if (!busy_q) begin
            if (in_xfer) begin
                sreg_d = din;
                beat_d = '0;
                busy_d = 1'b1;
            end
        end else if (beat_xfer && !at_last) begin
            sreg_d = sreg_shifted;
            beat_d = beat_q + BW'(1);
            if (in_xfer) begin
                hold_d       = din;
                hold_valid_d = 1'b1;
            end
        end else if (beat_xfer) begin
            // Last beat leaving: refill from hold first, else straight from din.
            if (hold_valid_q) begin
                sreg_d       = hold_q;
                hold_valid_d = 1'b0;
                beat_d       = '0;
            end else if (in_xfer) begin
                sreg_d = din;
                beat_d = '0;
            end else begin
                busy_d = 1'b0;
            end
        end else if (in_xfer) begin
            hold_d       = din;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q       <= '0;
            hold_q       <= '0;
            beat_q       <= '0;
            busy_q       <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            hold_q       <= hold_d;
            beat_q       <= beat_d;
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule
